// File: rtl/yuv422_stream_sched.sv
// rtl/yuv422_stream_sched.sv - raster scheduler feeding YUV422 pixels from an FWFT FIFO to the converter
// Optional 8-bar colour-bar source when YUV_SCHED_TPG_EN is defined.
module yuv422_stream_sched #(
  parameter int H_ACTIVE = 678,
  parameter int H_FP     = 1,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 1,
  parameter int V_ACTIVE = 297,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 1,
  parameter int V_BP     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        enable,
`ifdef YUV_SCHED_TPG_EN
  input  logic        tpg_sel,
`endif
  input  logic        fifo_empty,
  input  logic [19:0] fifo_dat,
  output logic        fifo_rd,
  output logic        yuv_hs,
  output logic        yuv_vs,
  output logic        yuv_de,
  output logic [9:0]  yuv_y,
  output logic [9:0]  yuv_c,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          run, act, wrap, use_fifo, starve;
  logic [19:0]   src_pix, out_pix;

  assign run  = (state == RUN);
  assign act  = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

`ifdef YUV_SCHED_TPG_EN
  logic       tpg_mode;
  logic [2:0] bar;
  logic [9:0] bar_y, bar_cb, bar_cr;

  // Source selection is latched only at a frame origin so a frame is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tpg_mode <= 1'b0;
    else if (cke && ((state == IDLE && enable) || (run && wrap)))
      tpg_mode <= tpg_sel;
  end

  always_comb begin
    bar = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));
    case (bar)
      3'd0:    begin bar_y = 10'h2D0; bar_cb = 10'h200; bar_cr = 10'h200; end
      3'd1:    begin bar_y = 10'h288; bar_cb = 10'h0B0; bar_cr = 10'h238; end
      3'd2:    begin bar_y = 10'h20C; bar_cb = 10'h270; bar_cr = 10'h0B0; end
      3'd3:    begin bar_y = 10'h1C0; bar_cb = 10'h120; bar_cr = 10'h0E8; end
      3'd4:    begin bar_y = 10'h150; bar_cb = 10'h2E0; bar_cr = 10'h318; end
      3'd5:    begin bar_y = 10'h104; bar_cb = 10'h190; bar_cr = 10'h350; end
      3'd6:    begin bar_y = 10'h08C; bar_cb = 10'h350; bar_cr = 10'h1C8; end
      default: begin bar_y = 10'h040; bar_cb = 10'h200; bar_cr = 10'h200; end
    endcase
  end

  assign use_fifo = !tpg_mode;
  assign src_pix  = tpg_mode ? {bar_y, (h_cnt[0] ? bar_cr : bar_cb)} : fifo_dat;
`else
  assign use_fifo = 1'b1;
  assign src_pix  = fifo_dat;
`endif

  assign starve  = act && use_fifo && fifo_empty;
  assign fifo_rd = cke && act && use_fifo && !fifo_empty;

  // A starved slot still consumes its raster position and shows black.
  always_comb begin
    out_pix = 20'h0;
    if (act)
      out_pix = starve ? {10'h040, 10'h200} : src_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      yuv_hs      <= 1'b0;
      yuv_vs      <= 1'b0;
      yuv_de      <= 1'b0;
      yuv_y       <= 10'h0;
      yuv_c       <= 10'h0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else if (cke) begin
      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable)
            state <= RUN;
        end
        default: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
          if (wrap && !enable)
            state <= IDLE;
        end
      endcase
      yuv_de         <= act;
      yuv_hs         <= run && (h_cnt >= HS_LO) && (h_cnt <= HS_HI);
      yuv_vs         <= run && (v_cnt >= VS_LO) && (v_cnt <= VS_HI);
      {yuv_y, yuv_c} <= out_pix;
      frame_start    <= act && (h_cnt == '0) && (v_cnt == '0);
      if (starve)
        underflow <= 1'b1;
      else if (underflow_clr)
        underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_yuv422_stream_sched.sv
// tb/tb_yuv422_stream_sched.sv - scoreboard bench for yuv422_stream_sched with a raster-position reference model
module tb_yuv422_stream_sched;
  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cke = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [19:0] fifo_dat = 20'h0;
  logic        underflow_clr = 1'b0;
  logic        fifo_rd, yuv_hs, yuv_vs, yuv_de, frame_start, underflow;
  logic [9:0]  yuv_y, yuv_c;
`ifdef YUV_SCHED_TPG_EN
  logic        tpg_sel = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [20:0] fifo_q[$];
  logic [19:0] exp_q[$];

  bit          m_run = 0, o_valid = 0, exp_uf = 0, m_tpg = 0;
  int          m_pos = 0, o_pos = 0, frames_done = 0, fslots = 0;
  logic [19:0] cur_pix = 20'h0;
  bit          ck_s = 0, en_s = 0, rst_s = 0, pop_s = 0, hole_s = 0, clr_s = 0, tpg_s = 0;

  yuv422_stream_sched #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .enable(enable),
`ifdef YUV_SCHED_TPG_EN
    .tpg_sel(tpg_sel),
`endif
    .fifo_empty(fifo_empty), .fifo_dat(fifo_dat), .fifo_rd(fifo_rd),
    .yuv_hs(yuv_hs), .yuv_vs(yuv_vs), .yuv_de(yuv_de), .yuv_y(yuv_y), .yuv_c(yuv_c),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit is_act(int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic logic [19:0] bar_pix(int h);
    logic [9:0] ty[8], tcb[8], tcr[8];
    int b;
    ty  = '{10'h2D0, 10'h288, 10'h20C, 10'h1C0, 10'h150, 10'h104, 10'h08C, 10'h040};
    tcb = '{10'h200, 10'h0B0, 10'h270, 10'h120, 10'h2E0, 10'h190, 10'h350, 10'h200};
    tcr = '{10'h200, 10'h238, 10'h0B0, 10'h0E8, 10'h318, 10'h350, 10'h1C8, 10'h200};
    b = h * 8 / HA;
    return {ty[b], (h % 2 == 1) ? tcr[b] : tcb[b]};
  endfunction

  // Monitor: advance the model by the edge just past, compare, then prime the FIFO for the next edge.
  always @(negedge clk) begin : mon
    bit new_out;
    int h, l;
    bit de_e, nxt_act;
    new_out = 0;
    if (!rst_n) begin
      m_run = 0; o_valid = 0; m_pos = 0; exp_uf = 0; cur_pix = 20'h0; fslots = 0; m_tpg = 0;
    end else if (rst_s && ck_s) begin
      new_out = 1;
      o_valid = m_run;
      o_pos = m_pos;
      if (hole_s) exp_uf = 1;
      else if (clr_s) exp_uf = 0;
      if (pop_s || hole_s) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fslots++;
      end
      if (m_run) begin
        if (m_pos == FT - 1) begin
          chk("slots_per_frame", fslots, m_tpg ? 0 : HA * VA);
          fslots = 0;
          frames_done++;
          m_pos = 0;
          if (!en_s) m_run = 0;
          else m_tpg = tpg_s;
        end else begin
          m_pos++;
        end
      end else if (en_s) begin
        m_run = 1; m_pos = 0; m_tpg = tpg_s; fslots = 0;
      end
    end
    h = o_pos % HT;
    l = o_pos / HT;
    de_e = o_valid && (h < HA) && (l < VA);
    if (new_out) begin
      if (!de_e) cur_pix = 20'h0;
      else if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL exp_queue: DUT pixel slot with no expected entry at %0t", $time);
        cur_pix = 20'h0;
      end else cur_pix = exp_q.pop_front();
    end
    chk("de", yuv_de, de_e);
    chk("hs", yuv_hs, o_valid && h >= HA + HF && h < HA + HF + HS);
    chk("vs", yuv_vs, o_valid && l >= VA + VF && l < VA + VF + VS);
    chk("frame_start", frame_start, de_e && o_pos == 0);
    chk("pixel", {yuv_y, yuv_c}, cur_pix);
    chk("underflow", underflow, exp_uf);
    fifo_empty = (fifo_q.size() == 0) || fifo_q[0][20];
    fifo_dat = (fifo_q.size() > 0) ? fifo_q[0][19:0] : 20'h0;
    #1;
    nxt_act = m_run && is_act(m_pos);
    chk("fifo_rd", fifo_rd, cke && nxt_act && !fifo_empty && !m_tpg);
    ck_s = cke; en_s = enable; rst_s = rst_n; clr_s = underflow_clr; pop_s = fifo_rd;
    hole_s = cke && nxt_act && !m_tpg && fifo_q.size() > 0 && fifo_q[0][20];
`ifdef YUV_SCHED_TPG_EN
    tpg_s = tpg_sel;
`else
    tpg_s = 0;
`endif
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_frame(int hole_idx, bit tpg);
    for (int k = 0; k < HA * VA; k++) begin
      logic [19:0] w;
      if (tpg) exp_q.push_back(bar_pix(k % HA));
      else if (k == hole_idx) begin
        fifo_q.push_back({1'b1, 20'h0});
        exp_q.push_back({10'h040, 10'h200});
      end else begin
        w = 20'($urandom);
        fifo_q.push_back({1'b0, w});
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic run_frames(int nf, bit toggle, int drop_line);
    int start, n;
    start = frames_done;
    n = 0;
    enable = 1'b1;
    while (n < 4000) begin
      if (toggle) cke = ~cke;
      if (frames_done == start + nf - 1 && m_run && m_pos / HT >= drop_line) enable = 1'b0;
      if (!enable && !m_run) break;
      tick();
      n++;
    end
    cke = 1'b1;
    if (n >= 4000) begin
      total++; bad++;
      $display("FAIL run_timeout: frames_done=%0d want %0d", frames_done - start, nf);
    end
    chk("frames_run", frames_done - start, nf);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_de"}, yuv_de, 0);
    chk({tag, "_hs"}, yuv_hs, 0);
    chk({tag, "_vs"}, yuv_vs, 0);
    chk({tag, "_pix"}, {yuv_y, yuv_c}, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_rd"}, fifo_rd, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    chk_quiet("reset");
    chk("reset_uf", underflow, 0);
    rst_n = 1'b1;
    cke = 1'b1;
    tick(2);

    load_frame(-1, 0);
    load_frame(-1, 0);
    run_frames(2, 0, 0);
    tick(3);
    chk_quiet("idle1");

    load_frame(3, 0);
    run_frames(1, 0, 0);
    chk("uf_sticky", underflow, 1);
    underflow_clr = 1'b1;
    load_frame(5, 0);
    run_frames(1, 0, 0);
    underflow_clr = 1'b0;
    tick(2);
    chk("uf_cleared", underflow, 0);

    load_frame(-1, 0);
    load_frame(-1, 0);
    run_frames(2, 1, 0);
    tick(2);

    load_frame(-1, 0);
    run_frames(1, 0, 2);
    tick(4);
    chk_quiet("idle_after_drop");
    load_frame(-1, 0);
    run_frames(1, 0, 3);
    tick(2);

    load_frame(-1, 0);
    enable = 1'b1;
    for (int n = 0; n < 400 && !(m_run && m_pos == HT + 5); n++) tick();
    chk("reached_line1_px5", m_run && m_pos == HT + 5, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    chk("async_reset_uf", underflow, 0);
    fifo_q.delete();
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    load_frame(-1, 0);
    run_frames(1, 0, 0);
    tick(2);

`ifdef YUV_SCHED_TPG_EN
    for (int k = 0; k < 4; k++) fifo_q.push_back({1'b0, 20'($urandom)});
    tpg_sel = 1'b1;
    load_frame(-1, 1);
    run_frames(1, 0, 0);
    tpg_sel = 1'b0;
    chk("tpg_fifo_untouched", fifo_q.size(), 4);
    chk("tpg_no_underflow", underflow, 0);
`endif

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
